// File: rtl/btn_debounce_step.sv
// Push-button debouncer: two-flop synchronizer, four-state qualification FSM,
// registered clean level plus single-cycle press/release strobes.
module btn_debounce_step #(
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       busy,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    CHK_HIGH  = 2'd1,
    IDLE_HIGH = 2'd2,
    CHK_LOW   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1, s2;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             level_n, press_n, release_n, busy_n;

  // Handshake: none. press_pulse/release_pulse are one-cycle strobes with no
  // backpressure; consumers must sample them on the cycle they are high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE_LOW;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      btn_level     <= level_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      busy          <= busy_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    level_n   = btn_level;
    press_n   = 1'b0;
    release_n = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (s2) begin
          state_n = CHK_HIGH;
          cnt_n   = CNT_W'(1);
        end else begin
          cnt_n = '0;
        end
      end
      CHK_HIGH: begin
        // Any low sample discards the partial qualification.
        if (!s2) begin
          state_n = IDLE_LOW;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE_HIGH;
          level_n = 1'b1;
          press_n = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!s2) begin
          state_n = CHK_LOW;
          cnt_n   = CNT_W'(1);
        end else begin
          cnt_n = '0;
        end
      end
      CHK_LOW: begin
        if (s2) begin
          state_n = IDLE_HIGH;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n   = IDLE_LOW;
          level_n   = 1'b0;
          release_n = 1'b1;
          cnt_n     = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE_LOW;
        cnt_n   = '0;
      end
    endcase
    busy_n = (state_n == CHK_HIGH) || (state_n == CHK_LOW);
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_btn_debounce_step.sv
// Bench for btn_debounce_step: sliding-window reference model feeds an expected
// pulse queue; a negedge monitor compares level, busy and every pulse.
module tb_btn_debounce_step;

  localparam int S     = 8;
  localparam int CNT_W = 4;
  localparam int W     = 33;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_in;
  logic       btn_level, press_pulse, release_pulse, busy;
  logic [1:0] state_dbg;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  logic [W-1:0] exp_q[$];

  // reference model state
  logic sync_q[$];
  logic win_q[$];
  logic m_level, m_busy, m_seen;
  bit   m_all;

  // monitor counters
  int       p_cnt = 0;
  int       r_cnt = 0;
  logic [3:0] step_cnt = '0;

  btn_debounce_step #(.STABLE_CYCLES(S), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .busy(busy),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: two-sample delay from btn_in to the value the debouncer sees, and a
  // level change is accepted once the last S seen samples all oppose the level.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      sync_q  = {1'b0, 1'b0};
      win_q   = {};
      m_level = 1'b0;
      m_busy  = 1'b0;
    end else begin
      m_seen = sync_q.pop_front();
      sync_q.push_back(btn_in);
      win_q.push_back(m_seen);
      if (win_q.size() > S) void'(win_q.pop_front());
      m_all = (win_q.size() == S);
      foreach (win_q[i]) if (win_q[i] == m_level) m_all = 1'b0;
      if (m_all) begin
        m_level = ~m_level;
        exp_q.push_back({m_level, cyc});
      end
      m_busy = (m_seen != m_level);
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      p_cnt    = 0;
      r_cnt    = 0;
      step_cnt = '0;
    end else begin
      chk("btn_level", 32'(btn_level), 32'(m_level));
      chk("busy", 32'(busy), 32'(m_busy));
      if (press_pulse && release_pulse) begin
        checks++;
        errors++;
        $display("FAIL pulse_overlap: press and release both high (cycle %0d)", cyc);
      end
      if (press_pulse || release_pulse) begin
        if (press_pulse) begin p_cnt++; step_cnt = step_cnt + 4'd1; end
        if (release_pulse) r_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: press=%0b release=%0b at cycle %0d, none expected",
                   press_pulse, release_pulse, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e !== {press_pulse, cyc}) begin
            errors++;
            $display("FAIL pulse: got press=%0b cycle %0d expected press=%0b cycle %0d",
                     press_pulse, cyc, e[32], e[31:0]);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0][31:0] <= cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_pulse: expected press=%0b at cycle %0d did not occur", e[32], e[31:0]);
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic v, input int n);
    @(negedge clk);
    btn_in = v;
    if (n > 1) idle(n - 1);
  endtask

  task automatic wait_pulse(input bit want_press, input int unsigned start,
                            input int unsigned delay, input string name);
    int unsigned seen_at = 0;
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (want_press ? press_pulse : release_pulse) begin
        got = 1'b1;
        seen_at = cyc;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: no pulse within 40 cycles, expected after %0d", name, delay);
    end else begin
      chk(name, seen_at - start, delay);
    end
  endtask

  task automatic pulse_reset(input int n);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (n) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    int unsigned k;
    int p0;
    logic [3:0] s0;
    logic v;
    rst    = 1'b1;
    btn_in = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_level", 32'(btn_level), 0);
    chk("reset_press", 32'(press_pulse), 0);
    chk("reset_release", 32'(release_pulse), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_state", 32'(state_dbg), 0);
    rst = 1'b0;
    idle(4);

    // clean press and release
    @(negedge clk); btn_in = 1'b1; k = cyc + 1;
    wait_pulse(1'b1, k, S + 1, "press_latency");
    idle(5);
    @(negedge clk); btn_in = 1'b0; k = cyc + 1;
    wait_pulse(1'b0, k, S + 1, "release_latency");
    idle(5);

    // glitch shorter than the qualification window
    p0 = p_cnt;
    drive(1'b1, 5);
    drive(1'b0, 20);
    chk("glitch_no_press", 32'(p_cnt), 32'(p0));
    chk("glitch_busy_low", 32'(busy), 0);

    // bounce train ending high
    s0 = step_cnt;
    for (int i = 0; i < 10; i++) drive(~i[0], 3);
    @(negedge clk); btn_in = 1'b1; k = cyc + 1;
    wait_pulse(1'b1, k, S + 1, "bounce_press_latency");
    idle(20);
    chk("bounce_step_count", 32'(step_cnt), 32'(s0 + 4'd1));
    drive(1'b0, 20);

    // reset in the middle of a rise qualification
    @(negedge clk); btn_in = 1'b1;
    idle(4);
    chk("midcheck_busy", 32'(busy), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_level", 32'(btn_level), 0);
    chk("midrst_press", 32'(press_pulse), 0);
    chk("midrst_release", 32'(release_pulse), 0);
    chk("midrst_busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    k = cyc;
    wait_pulse(1'b1, k, S + 2, "post_reset_press_latency");
    drive(1'b0, 20);

    // random runs of bouncing and stable levels
    for (int i = 0; i < 60; i++) begin
      v = 1'($urandom_range(0, 1));
      drive(v, int'($urandom_range(1, 14)));
    end
    drive(1'b0, 20);

    // 20 clean press/release pairs from a fresh reset
    pulse_reset(2);
    idle(3);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 20);
      drive(1'b0, 20);
    end
    idle(5);
    chk("pairs_press_count", 32'(p_cnt), 20);
    chk("pairs_release_count", 32'(r_cnt), 20);
    chk("pairs_step_count", 32'(step_cnt), 4);
    chk("exp_queue_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
